// File: rtl/alu_entry_sequencer.sv
// alu_entry_sequencer: captures operands/opcode on ENTER pulses, launches one ALU op and holds its result.
module alu_entry_sequencer #(
  parameter int WIDTH        = 8,
  parameter int OPW          = 4,
  parameter int DONE_TIMEOUT = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             enter_pulse,
  input  logic             clear_pulse,
  input  logic [WIDTH-1:0] sw_data,
  input  logic [OPW-1:0]   sw_op,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic [OPW-1:0]   opcode,
  output logic             alu_start,
  output logic [WIDTH-1:0] result_q,
  output logic             result_valid,
  output logic             timeout_err,
  output logic [2:0]       state_o
);
  localparam int CW = $clog2(DONE_TIMEOUT);
  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4,
    SHOW   = 3'd5
  } state_t;
  state_t           state_q = GET_A;
  logic [CW-1:0]    cnt_q   = '0;
  logic [WIDTH-1:0] a_q     = '0;
  logic [WIDTH-1:0] b_q     = '0;
  logic [OPW-1:0]   op_q    = '0;
  logic [WIDTH-1:0] res_q   = '0;
  logic             start_q = 1'b0;
  logic             valid_q = 1'b0;
  logic             terr_q  = 1'b0;
  // Clear behaves exactly like reset, so both share one branch.
  always_ff @(posedge clk_in) begin
    if (rst || clear_pulse) begin
      state_q <= GET_A;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        GET_A: if (enter_pulse) begin
          a_q     <= sw_data;
          state_q <= GET_B;
        end
        GET_B: if (enter_pulse) begin
          b_q     <= sw_data;
          state_q <= GET_OP;
        end
        GET_OP: if (enter_pulse) begin
          op_q    <= sw_op;
          start_q <= 1'b1;
          state_q <= START;
        end
        START: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          if (alu_done) begin
            res_q   <= alu_result;
            valid_q <= 1'b1;
            terr_q  <= 1'b0;
            state_q <= SHOW;
          end else if (cnt_q == CW'(DONE_TIMEOUT - 1)) begin
            terr_q  <= 1'b1;
            valid_q <= 1'b0;
            state_q <= SHOW;
          end
        end
        SHOW: if (enter_pulse) begin
          a_q     <= sw_data;
          valid_q <= 1'b0;
          terr_q  <= 1'b0;
          state_q <= GET_B;
        end
        default: state_q <= GET_A;
      endcase
    end
  end
  assign operand_a    = a_q;
  assign operand_b    = b_q;
  assign opcode       = op_q;
  assign alu_start    = start_q;
  assign result_q     = res_q;
  assign result_valid = valid_q;
  assign timeout_err  = terr_q;
  assign state_o      = state_q;
endmodule

// File: tb/tb_alu_entry_sequencer.sv
// tb_alu_entry_sequencer: directed plan scenarios plus randomized operations against a transaction-level model.
module tb_alu_entry_sequencer;
  localparam int W  = 8;
  localparam int OW = 4;
  localparam int TO = 16;
  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          enter_pulse = 1'b0;
  logic          clear_pulse = 1'b0;
  logic [W-1:0]  sw_data = '0;
  logic [OW-1:0] sw_op = '0;
  logic          alu_done = 1'b0;
  logic [W-1:0]  alu_result = '0;
  logic [W-1:0]  operand_a, operand_b, result_q;
  logic [OW-1:0] opcode;
  logic          alu_start, result_valid, timeout_err;
  logic [2:0]    state_o;
  int checks = 0;
  int failures = 0;
  logic [W-1:0]  m_a, m_b, m_res;
  logic [OW-1:0] m_op;
  logic          m_valid, m_terr;
  int            m_state;

  alu_entry_sequencer #(.WIDTH(W), .OPW(OW), .DONE_TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst(rst), .enter_pulse(enter_pulse), .clear_pulse(clear_pulse),
    .sw_data(sw_data), .sw_op(sw_op), .alu_done(alu_done), .alu_result(alu_result),
    .operand_a(operand_a), .operand_b(operand_b), .opcode(opcode), .alu_start(alu_start),
    .result_q(result_q), .result_valid(result_valid), .timeout_err(timeout_err), .state_o(state_o)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"}, 32'(state_o), 32'(m_state));
    check({tag, ".a"}, 32'(operand_a), 32'(m_a));
    check({tag, ".b"}, 32'(operand_b), 32'(m_b));
    check({tag, ".op"}, 32'(opcode), 32'(m_op));
    check({tag, ".res"}, 32'(result_q), 32'(m_res));
    check({tag, ".valid"}, 32'(result_valid), 32'(m_valid));
    check({tag, ".terr"}, 32'(timeout_err), 32'(m_terr));
  endtask

  task automatic m_zero();
    m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_valid = 0; m_terr = 0; m_state = 0;
  endtask

  task automatic press(input logic [W-1:0] d, input logic [OW-1:0] op);
    sw_data = d; sw_op = op; enter_pulse = 1'b1;
    tick();
    enter_pulse = 1'b0;
  endtask

  // Full entry + launch; done arrives on WAIT cycle k (k outside 1..TO means never).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OW-1:0] op,
                        input int k, input logic [W-1:0] res);
    int n;
    press(a, 4'h0);
    m_a = a; m_valid = 0; m_terr = 0; m_state = 1; check_all("cap_a");
    press(b, 4'h0);
    m_b = b; m_state = 2; check_all("cap_b");
    press(8'h00, op);
    m_op = op; m_state = 3; check_all("start");
    check("alu_start_hi", 32'(alu_start), 32'd1);
    tick();
    m_state = 4; check_all("wait");
    check("alu_start_lo", 32'(alu_start), 32'd0);
    n = 0;
    while (state_o == 3'd4 && n < TO + 4) begin
      n++;
      alu_done = (n == k); alu_result = res;
      enter_pulse = (n == 2); sw_data = ~a;
      tick();
      alu_done = 1'b0; enter_pulse = 1'b0;
    end
    if (k >= 1 && k <= TO) begin
      m_res = res; m_valid = 1; m_terr = 0;
      check("wait_len", 32'(n), 32'(k));
    end else begin
      m_valid = 0; m_terr = 1;
      check("timeout_len", 32'(n), 32'(TO));
    end
    m_state = 5; check_all("show");
  endtask

  initial begin
    m_zero();
    tick(); tick();
    rst = 1'b0;
    check_all("reset");
    check("reset.start", 32'(alu_start), 32'd0);
    alu_done = 1'b1; alu_result = 8'h55;
    tick();
    alu_done = 1'b0;
    check_all("stray_done");
    run_op(8'h12, 8'h34, 4'h3, 1, 8'h46);
    run_op(8'hAA, 8'h01, 4'h5, 0, 8'h77);
    press(8'h21, 4'h0); m_a = 8'h21; m_valid = 0; m_terr = 0; m_state = 1; check_all("chain_a");
    press(8'h22, 4'h0); m_b = 8'h22; m_state = 2; check_all("chain_b");
    sw_op = 4'h9; enter_pulse = 1'b1; clear_pulse = 1'b1;
    tick();
    enter_pulse = 1'b0; clear_pulse = 1'b0;
    m_zero(); check_all("clr_prio");
    check("clr_prio.start", 32'(alu_start), 32'd0);
    tick();
    check("clr_prio.start2", 32'(alu_start), 32'd0);
    check("clr_prio.state2", 32'(state_o), 32'd0);
    press(8'h01, 4'h0); press(8'h02, 4'h0); press(8'h00, 4'h4);
    tick();
    check("abandon.wait", 32'(state_o), 32'd4);
    clear_pulse = 1'b1;
    tick();
    clear_pulse = 1'b0;
    tick();
    alu_done = 1'b1; alu_result = 8'hFF;
    tick();
    alu_done = 1'b0;
    m_zero(); check_all("abandon");
    press(8'h5A, 4'h0);
    m_a = 8'h5A; m_state = 1; check_all("pre_rst");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_zero(); check_all("rst_mid");
    check("rst_mid.start", 32'(alu_start), 32'd0);
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        clear_pulse = 1'b1;
        tick();
        clear_pulse = 1'b0;
        m_zero(); check_all("rnd_clr");
      end
      run_op(W'($urandom), W'($urandom), OW'($urandom), int'($urandom_range(1, 20)), W'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_entry_sequencer.md
Name: alu_entry_sequencer

Overview:
- Downstream consumer of the button edge-pulse stage: takes single-cycle rising-edge pulses from the ENTER and CLEAR buttons and steps through operand/opcode capture from board switches.
- Launches one ALU operation with a single-cycle start strobe, then waits for completion with a timeout.
- Holds the result for display until the next entry.

Parameters:
- WIDTH, 8, operand/result width in bits
- OPW, 4, opcode width in bits
- DONE_TIMEOUT, 16, cycles allowed in WAIT for alu_done before error (>=2)

Ports:
- clk_in  input  1  system clock
- rst  input  1  synchronous, active-high reset
- enter_pulse  input  1  one-cycle rise pulse from the ENTER button edge stage
- clear_pulse  input  1  one-cycle rise pulse from the CLEAR button edge stage
- sw_data  input  WIDTH  switch value sampled as an operand
- sw_op  input  OPW  switch value sampled as the opcode
- alu_done  input  1  ALU completion strobe
- alu_result  input  WIDTH  ALU result, valid when alu_done=1
- operand_a  output  WIDTH  captured operand A
- operand_b  output  WIDTH  captured operand B
- opcode  output  OPW  captured opcode
- alu_start  output  1  one-cycle launch strobe
- result_q  output  WIDTH  held result
- result_valid  output  1  result_q is valid
- timeout_err  output  1  last operation timed out
- state_o  output  3  current state encoding, for LEDs/debug

Behaviour:
- Reset is synchronous and active-high on rst, sampled at posedge clk_in. Reset clears all outputs to 0 and sets state to GET_A.
- All outputs are registered. The same values also apply as power-up initial values.
- State encoding: GET_A=0, GET_B=1, GET_OP=2, START=3, WAIT=4, SHOW=5. Codes 6 and 7 return to GET_A on the next cycle.
- GET_A: on enter_pulse, operand_a<=sw_data, go to GET_B.
- GET_B: on enter_pulse, operand_b<=sw_data, go to GET_OP.
- GET_OP: on enter_pulse, opcode<=sw_op, go to START.
- START (exactly 1 cycle):
  - alu_start=1 during this cycle only.
  - Wait counter is cleared.
  - Unconditionally go to WAIT.
- WAIT:
  - The counter increments each cycle.
  - If alu_done=1: result_q<=alu_result, result_valid<=1, timeout_err<=0, go to SHOW.
  - Else, if the counter reaches DONE_TIMEOUT-1: timeout_err<=1, result_valid<=0, go to SHOW.
  - If alu_done=1 on the timeout cycle, done wins.
- SHOW: hold all outputs. On enter_pulse:
  - operand_a<=sw_data.
  - result_valid<=0, timeout_err<=0.
  - Go to GET_B, so the first press both clears the display and starts a new entry.
- enter_pulse is ignored in START and WAIT.
- alu_done is ignored in every state except WAIT.
- clear_pulse, in any state:
  - Next state is GET_A.
  - operand_a, operand_b, opcode, result_q, result_valid and timeout_err are zeroed.
  - alu_start is 0 the next cycle.
  - clear_pulse has priority over simultaneous enter_pulse and alu_done.
  - Clear during WAIT abandons the operation; a late alu_done is then ignored.
- rst has priority over everything; reset mid-WAIT behaves like clear.
- Latency:
  - From the GET_OP enter_pulse at cycle N, alu_start is high at cycle N+1 only.
  - From alu_done at cycle M, result_q and result_valid update at M+1.
- Holding enter_pulse high for several cycles is outside the contract (the edge stage guarantees one cycle). Each high cycle counts as one press.

Test Plan:
- Basic operation:
  - Stimulus: rst, then enter with sw_data=0x12, enter with sw_data=0x34, enter with sw_op=0x3; alu_done one cycle after alu_start with alu_result=0x46.
  - Required: operand_a=0x12, operand_b=0x34, opcode=0x3; alu_start high for exactly 1 cycle; result_q=0x46 with result_valid=1; state_o=5.
- Timeout (DONE_TIMEOUT=16):
  - Stimulus: complete entry, never assert alu_done.
  - Required: after 16 WAIT cycles, timeout_err=1, result_valid=0, state_o=5.
- Chained entry:
  - Stimulus: in SHOW, enter with sw_data=0xAA.
  - Required: result_valid=0, timeout_err=0, operand_a=0xAA, state_o=1.
- Clear priority:
  - Stimulus: in GET_OP, enter_pulse and clear_pulse in the same cycle.
  - Required: state_o=0, all captured values 0, no alu_start.
- Abandoned operation:
  - Stimulus: clear_pulse during WAIT, then alu_done two cycles later with alu_result=0xFF.
  - Required: result_q=0, result_valid=0, state_o=0.
- Ignored inputs and reset:
  - Stimulus: enter_pulse during WAIT; stray alu_done in GET_A; rst mid-GET_B.
  - Required: no state change from the enter or the stray alu_done; after rst, all outputs 0 and state_o=0.
